// File: rtl/fft_pkg.sv
// fft_pkg: definitions shared by the FFT pair serializer slice.
//   FFT_N / FFT_WORD_SIZE : default frame length and sample width.
//   ADDR_W                : bits needed for an in-frame sample index.
//   pair_t                : one FFT output-read beat {samp1, samp2}.
//   phase_e               : serializer phase (PH1 emits samp1, PH2 emits samp2).
package fft_pkg;

    localparam int FFT_N         = 32;
    localparam int FFT_WORD_SIZE = 16;
    localparam int ADDR_W        = $clog2(FFT_N);

    typedef struct packed {
        logic [FFT_WORD_SIZE-1:0] samp1;
        logic [FFT_WORD_SIZE-1:0] samp2;
    } pair_t;

    typedef enum logic {
        PH1 = 1'b0,
        PH2 = 1'b1
    } phase_e;

endpackage

// File: rtl/fft_pair_serializer_if.sv
// fft_pair_serializer_if: pair input and serial output signals of the
// serializer.
//   in_valid/in_samp1/in_samp2/in_ready : two-sample input beat, in_ready is
//                                         the upstream enable.
//   out_samp/out_valid/out_ready/out_last : one-sample stream with frame end.
//   overflow                            : sticky dropped-pair indicator.
//   out_index                           : sample index (only with FFT_SER_INDEX_EN).
// Modports: slave = serializer side, master = upstream/downstream side.
interface fft_pair_serializer_if #(
    parameter int N         = 32,
    parameter int word_size = 16
);
    logic                 in_valid;
    logic [word_size-1:0] in_samp1;
    logic [word_size-1:0] in_samp2;
    logic                 in_ready;
    logic [word_size-1:0] out_samp;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 overflow;
`ifdef FFT_SER_INDEX_EN
    logic [$clog2(N)-1:0] out_index;

    modport slave (
        input  in_valid, in_samp1, in_samp2, out_ready,
        output in_ready, out_samp, out_valid, out_last, overflow, out_index
    );

    modport master (
        output in_valid, in_samp1, in_samp2, out_ready,
        input  in_ready, out_samp, out_valid, out_last, overflow, out_index
    );
`else
    modport slave (
        input  in_valid, in_samp1, in_samp2, out_ready,
        output in_ready, out_samp, out_valid, out_last, overflow
    );

    modport master (
        output in_valid, in_samp1, in_samp2, out_ready,
        input  in_ready, out_samp, out_valid, out_last, overflow
    );
`endif
endinterface

// File: rtl/fft_pair_fifo.sv
// fft_pair_fifo: synchronous FIFO holding sample pairs.
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO).
//   push, wdata  : write wdata at the tail (ignored when full).
//   pop, rdata   : rdata shows the head; pop discards it (ignored when empty).
//   full, empty  : derived from the occupancy count.
module fft_pair_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fft_pair_serializer.sv
// fft_pair_serializer: buffers FFT output pairs and re-emits them one sample
// per cycle with valid/ready, marking the last sample of each N-point frame.
//   clk     : rising-edge clock.
//   reset_n : asynchronous active-low reset; discards buffered data and
//             restarts the frame count.
//   bus     : fft_pair_serializer_if.slave (pair input, serial output,
//             sticky overflow).
// Optional: define FFT_SER_INDEX_EN to add bus.out_index, the in-frame index
// of the held sample.
module fft_pair_serializer
    import fft_pkg::*;
#(
    parameter int N          = 32,
    parameter int word_size  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    fft_pair_serializer_if.slave   bus
);
    localparam int CNT_W = $clog2(N);
    localparam int PW    = 2 * word_size;

    logic [PW-1:0]        fifo_rdata;
    logic                 fifo_full, fifo_empty;
    logic                 push, pop, load_en, load;

    phase_e               phase_q, phase_d;
    logic [word_size-1:0] out_samp_q, out_samp_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 overflow_q, overflow_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
`ifdef FFT_SER_INDEX_EN
    logic [CNT_W-1:0]     index_q, index_d;
`endif

    assign push = bus.in_valid && !fifo_full;

    fft_pair_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (PW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   ({bus.in_samp1, bus.in_samp2}),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // cnt_q is the frame index of the next sample to enter the output stage;
    // every loaded sample is later accepted unless reset intervenes.
    always_comb begin
        phase_d     = phase_q;
        out_samp_d  = out_samp_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        cnt_d       = cnt_q;
`ifdef FFT_SER_INDEX_EN
        index_d     = index_q;
`endif
        overflow_d  = overflow_q || (bus.in_valid && fifo_full);
        pop         = 1'b0;
        load_en     = !out_valid_q || bus.out_ready;
        load        = load_en && !fifo_empty;

        if (load) begin
            out_valid_d = 1'b1;
            out_last_d  = (cnt_q == CNT_W'(N - 1));
            cnt_d       = cnt_q + 1'b1;
`ifdef FFT_SER_INDEX_EN
            index_d     = cnt_q;
`endif
            if (phase_q == PH1) begin
                out_samp_d = fifo_rdata[PW-1:word_size];
                phase_d    = PH2;
            end else begin
                // Head pair is fully emitted once samp2 is loaded.
                out_samp_d = fifo_rdata[word_size-1:0];
                pop        = 1'b1;
                phase_d    = PH1;
            end
        end else if (load_en) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= PH1;
            out_samp_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
            cnt_q       <= '0;
`ifdef FFT_SER_INDEX_EN
            index_q     <= '0;
`endif
        end else begin
            phase_q     <= phase_d;
            out_samp_q  <= out_samp_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
            cnt_q       <= cnt_d;
`ifdef FFT_SER_INDEX_EN
            index_q     <= index_d;
`endif
        end
    end

    assign bus.in_ready  = !fifo_full;
    assign bus.out_samp  = out_samp_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.overflow  = overflow_q;
`ifdef FFT_SER_INDEX_EN
    assign bus.out_index = index_q;
`endif

endmodule

// File: doc/fft_pair_serializer.md
Name: fft_pair_serializer

Overview:
- Sits directly downstream of the FFT output-read stage, which presents two result samples per cycle with a valid flag.
- Buffers those sample pairs in a small FIFO and re-emits them as a one-sample-per-cycle stream with a valid/ready handshake.
- Marks the last sample of each N-point frame so the stream consumer can delimit frames.
- Its in_ready drives the upstream stage's en.

Parameters:
- N, 32, FFT frame length in samples; power of 2, >= 4.
- word_size, 16, sample width in bits.
- FIFO_DEPTH, 4, pair FIFO depth in entries; power of 2, >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  a sample pair is presented this cycle.
- in_samp1  in  word_size  first (even-index) sample of the pair.
- in_samp2  in  word_size  second (odd-index) sample of the pair.
- in_ready  out  1  FIFO not full; drives upstream en.
- out_samp  out  word_size  serialized sample.
- out_valid  out  1  out_samp is valid.
- out_ready  in  1  downstream accepts out_samp this cycle.
- out_last  out  1  out_samp is sample N-1 of its frame.
- overflow  out  1  sticky: a pair arrived while the FIFO was full.

Behaviour:
- Reset (asynchronous, reset_n low):
  - FIFO empty, phase=0, sample counter=0.
  - out_valid=0, out_last=0, out_samp=0, overflow=0, in_ready=1.
  - Reset mid-frame discards all buffered data and restarts the frame count at 0.
- in_ready = !fifo_full, combinational from the occupancy count.
- Push: in_valid && in_ready at a rising edge writes {in_samp1, in_samp2} to the FIFO tail.
- Overflow: in_valid && !in_ready drops the pair and sets overflow=1. Overflow clears only on reset.
- Output register stage: out_samp, out_valid and out_last are registered. The stage is loaded when it is empty or being consumed (out_valid && out_ready).
- Phase FSM, two states:
  - PH1: load head.samp1 if the FIFO is non-empty, then go to PH2.
  - PH2: load head.samp2, pop the FIFO head, then go to PH1.
  - The state advances only when a load occurs.
  - If PH1 has no load because the FIFO is empty: out_valid drops to 0 after any held sample is consumed.
- Stall: out_valid && !out_ready holds out_samp, out_valid and out_last stable. No advance, no pop.
- Latency: a pair pushed at edge E into an empty FIFO with an empty output stage shows samp1 with out_valid=1 after edge E+1, and samp2 after the edge where samp1 is accepted.
- Sustained throughput: one sample per cycle with out_ready=1. The upstream pair rate is therefore limited to one pair per two cycles; in_ready deasserts when the FIFO fills.
- Sample counter: log2(N) bits, increments on each accepted output sample and wraps N-1 to 0.
- out_last=1 exactly when the registered sample's index equals N-1.
- Simultaneous push and pop in one cycle: occupancy is unchanged. Allowed when full only if the pop happens that cycle, but in_ready stays based on the pre-edge full flag, so no push is accepted while full.
- Pointers: log2(FIFO_DEPTH) bits with wrap-around, plus an occupancy count of width log2(FIFO_DEPTH)+1.

Optional Feature:
- Macro: FFT_SER_INDEX_EN.
- Defined:
  - Adds output port out_index [log2(N)-1:0], registered alongside out_samp, equal to the sample counter value of the held sample.
  - Reset value 0.
  - Held stable under stall.
- Undefined: no out_index port. The counter still exists internally for out_last.

Decomposition:
- Shared package fft_pkg holds:
  - constant ADDR_W = $clog2(N);
  - a pair type {samp1, samp2} of 2*word_size bits;
  - a phase enum {PH1, PH2}.
- One natural sub-module: fft_pair_fifo. It is a synchronous FIFO with parameters FIFO_DEPTH and width 2*word_size, and ports push, pop, wdata, rdata, full, empty. The top level holds the phase FSM, output register, counters and overflow flag.

Test Plan:
- Reset mid-stream: push 3 pairs, assert reset_n=0 for 1 cycle -> out_valid=0, overflow=0, in_ready=1; the next pair pushed emits first with out_last=0.
- Single pair: push {0x0011, 0x0022} with out_ready=1 -> out_samp=0x0011 one cycle after the push, then 0x0022, then out_valid=0.
- Full frame, N=32, one pair pushed every 2 cycles with out_ready=1 -> 32 contiguous samples 0..31 in order; out_last=1 only on sample 31; frame 2 restarts the index at 0.
- Backpressure: out_ready=0 for 10 cycles while pushing -> out_samp is held stable; in_ready=0 after 4 pairs are buffered plus the held stage; on release, all samples emerge in order and none are lost.
- Overflow: force in_valid=1 while in_ready=0 -> overflow=1 and stays sticky; the dropped pair never appears; other data is intact.
- With FFT_SER_INDEX_EN defined: out_index tracks 0..N-1 and wraps; it is held during stalls.
